// File: rtl/ram_burst_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_master_pkg
//  Purpose  : Shared CPU package. Holds the burst-master state encoding and
//             the address-map constants used when stepping through the
//             unified instruction/data RAM.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ram_burst_master_pkg;

    // Flat byte-address map of the unified RAM port.
    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } burst_state_t;

    // Next word address; wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
    function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
        return a + WORD_BYTES;
    endfunction

endpackage : ram_burst_master_pkg
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_master
//  Purpose  : Burst initiator for the unified RAM main port. Accepts one
//             command (base, count, direction); write bursts drain an inbound
//             valid/ready stream into the RAM, read bursts return RAM words on
//             an outbound valid/ready stream through a one-entry register.
//  Ports    : clk_100M, rst_n (async, active low), clk_en
//             cmd_start/cmd_write/cmd_addr/cmd_count  - command
//             busy/done/err                           - status
//             in_data/in_valid/in_ready               - write stream
//             out_data/out_valid/out_ready            - read stream
//             mem_addr/mem_wr_en/mem_w_data/mem_r_data - RAM port
//  Revision : 1.0  initial release
// ============================================================================
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              cmd_start,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_addr,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       mem_addr,
    output logic              mem_wr_en,
    output logic [31:0]       mem_w_data,
    input  logic [31:0]       mem_r_data
);

    burst_state_t       state_q,     state_d;
    logic [ADDR_W-1:0]  cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q,       err_d;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (cmd_count == '0) begin
                        state_d = FINISH;
                    end else begin
                        cur_addr_d  = cmd_addr;
                        remaining_d = cmd_count;
                        state_d     = cmd_write ? WRITE : READ;
                    end
                end
            end

            WRITE: begin
                // clk_en gates the handshake so a word is only consumed on a
                // cycle where the RAM actually commits it.
                in_ready  = clk_en;
                mem_wr_en = in_valid & clk_en;
                if (in_valid && clk_en) begin
                    cur_addr_d  = next_word_addr(cur_addr_q);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = FINISH;
                    end
                end
            end

            READ: begin
                // Refill the output register whenever it is empty or being
                // drained this cycle, giving one word per cycle at full rate.
                if ((remaining_q != '0) && (!out_valid_q || out_ready)) begin
                    out_data_d  = mem_r_data;
                    out_valid_d = 1'b1;
                    cur_addr_d  = next_word_addr(cur_addr_q);
                    remaining_d = remaining_q - CNT_W'(1);
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (out_valid_q && out_ready && (remaining_q == '0)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign mem_addr   = cur_addr_q;
    assign mem_w_data = in_data;

endmodule : ram_burst_master
`default_nettype wire

// File: doc/ram_burst_master.md
# ram_burst_master

Burst initiator for the unified instruction/data RAM's main port. It accepts a single command (base address, word count, direction) and drives the RAM's wr_en/addr/w_data/r_data port. Write bursts take words from an inbound valid/ready stream; read bursts return words on an outbound valid/ready stream. Used by the program loader and by memory-dump logic alongside the CPU. Instruction and data regions are split inside the RAM, so this block works only with flat byte addresses.

## Interface
- CNT_W, 16, width of word-count field; max burst 2^CNT_W−1 words
- clk_100M  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable, shared with the RAM; RAM writes commit only when high
- cmd_start  in  1  one-cycle command strobe; ignored unless idle
- cmd_write  in  1  1 = write burst, 0 = read burst; sampled with cmd_start
- cmd_addr  in  32  byte base address; must be word aligned
- cmd_count  in  CNT_W  number of 32-bit words
- busy  out  1  high from accept to completion
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a rejected command
- in_data  in  32  write-stream word
- in_valid  in  1  write-stream valid
- in_ready  out  1  write-stream ready
- out_data  out  32  read-stream word, registered
- out_valid  out  1  read-stream valid
- out_ready  in  1  read-stream ready
- mem_addr  out  32  to RAM addr
- mem_wr_en  out  1  to RAM wr_en
- mem_w_data  out  32  to RAM w_data
- mem_r_data  in  32  from RAM r_data; combinational read of mem_addr

## Operation
- State machine has four states: IDLE, WRITE, READ, FINISH.
- IDLE, on cmd_start:
  - If cmd_addr[1:0]≠0: err is pulsed next cycle and the state stays IDLE.
  - Else if cmd_count=0: go to FINISH; no memory access.
  - Else: load cur_addr←cmd_addr and remaining←cmd_count, then go to WRITE or READ.
- WRITE:
  - in_ready = clk_en. mem_wr_en = in_valid & clk_en. mem_w_data = in_data (combinational). mem_addr = cur_addr.
  - On each handshake: cur_addr+=4 and remaining−=1. When remaining reaches 0, go to FINISH.
- READ: uses a one-entry output register.
  - Load condition: remaining≠0 and (¬out_valid or out_ready).
  - On load: out_data←mem_r_data, out_valid←1, cur_addr+=4, remaining−=1.
  - If out_valid & out_ready and no load occurs, out_valid←0.
  - Go to FINISH on the cycle the last word is handshaken, i.e. out_valid & out_ready & remaining=0.
  - clk_en has no effect on reads.
- FINISH: done=1 for one cycle, then IDLE.
- busy = state≠IDLE.
- cmd_start while busy: ignored, with no err pulse.
- Address arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0. Boundaries between instruction and data regions are not checked.
- Reset mid-burst: all state is cleared immediately. Words already written stay in the RAM. A partial read word is discarded.
- Reset values: busy=0, done=0, err=0, in_ready=0, out_valid=0, out_data=0, mem_wr_en=0, mem_addr=0, mem_w_data=in_data (passthrough). cur_addr=0, remaining=0, state=IDLE.

## Timing
- Command accept → first possible write handshake: 1 cycle, the first cycle in WRITE.
- Write throughput: one word per cycle while in_valid and clk_en are both high.
- Final write → done: done is high in the cycle after the last write edge.
- Command accept → first out_valid: 2 cycles. Cycle 1 enters READ and loads; out_valid is high from cycle 2.
- Read throughput: one word per cycle with out_ready held high.
- Last read handshake → done: 1 cycle.
- Bad command → err: 1 cycle.
- Back-to-back commands: the earliest next cmd_start acceptance is the cycle after done.

## Structure
- State enum burst_state_t {IDLE, WRITE, READ, FINISH} lives in the shared CPU package next to the address map constants.
- Single module; no sub-module is needed. The output register stays inline.

## Test plan
- Write burst: cmd_addr=0x0000_0100, count=3, in_data 0xA, 0xB, 0xC with in_valid held high → RAM words at 0x100, 0x104, 0x108 = A, B, C; done pulses exactly once; busy is high for 4 cycles.
- clk_en gating: same burst with clk_en toggling 1,0,1,0,… → in_ready and mem_wr_en are low on clk_en=0 cycles; the same final RAM contents result in 6 cycles.
- Read burst with backpressure: preload 0x100–0x10C with 1..4, read count=4, out_ready pattern 1,0,0,1,1,1 → out_data sequence is 1, 2, 3, 4 with no drop or duplicate; done comes 1 cycle after the 4th handshake.
- Errors and edge commands:
  - cmd_addr=0x102 → err pulse, busy stays 0, no mem_wr_en.
  - count=0 → done next cycle, no access.
  - cmd_start while busy → ignored.
- Wrap: write count=2 at 0xFFFF_FFFC → second write lands at mem_addr=0x0000_0000.
- Reset mid-burst: deassert rst_n after 2 of 5 writes → outputs go to reset values asynchronously; the first 2 words are kept; a new command then completes normally.
